// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants for the iterative AES key schedule:
//   - mode encoding (AES-128 / AES-256)
//   - last round-key index for each mode
//   - FSM state type
//   - rcon table, exposed through rcon_byte()
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic MODE_AES128 = 1'b0;
    localparam logic MODE_AES256 = 1'b1;

    localparam logic [3:0] LAST_IDX_128 = 4'd10;
    localparam logic [3:0] LAST_IDX_256 = 4'd14;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Round constant table, indexed from 1. Index 0 and anything beyond
    // the table yield 0 so callers can use the result unconditionally.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box, one byte in, one byte out.
// Ports:
//   in_byte  - input byte
//   out_byte - SubBytes(in_byte)
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Table stored MSB-first: entry i occupies bits [8*i : 8*i+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/key_sched_iter_key_step.sv
// ---------------------------------------------------------------------------
// key_step
// One four-word expansion step of the AES key schedule (combinational).
//   t  = SubWord(rot_en ? RotWord(src_word) : src_word) ^ {rcon_in, 24'h0}
//   y0 = w0 ^ t, y1 = w1 ^ y0, y2 = w2 ^ y1, y3 = w3 ^ y2
// Ports:
//   base_key - four words w0..w3 being extended (w0 in bits 127:96)
//   src_word - word fed through RotWord/SubWord
//   rot_en   - apply RotWord before SubWord
//   rcon_in  - round constant XORed into the top byte (0 for none)
//   next_key - resulting four words y0..y3
// ---------------------------------------------------------------------------
module key_step (
    input  logic [127:0] base_key,
    input  logic [31:0]  src_word,
    input  logic         rot_en,
    input  logic [7:0]   rcon_in,
    output logic [127:0] next_key
);

    logic [31:0] sel_word;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic [31:0] y0, y1, y2, y3;

    // RotWord is a one-byte left rotation of the word.
    assign sel_word = rot_en ? {src_word[23:0], src_word[31:24]} : src_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sel_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    assign t_word = sub_word ^ {rcon_in, 24'h000000};

    assign y0 = base_key[127:96] ^ t_word;
    assign y1 = base_key[95:64]  ^ y0;
    assign y2 = base_key[63:32]  ^ y1;
    assign y3 = base_key[31:0]   ^ y2;

    assign next_key = {y0, y1, y2, y3};

endmodule

// File: rtl/key_sched_iter.sv
// ---------------------------------------------------------------------------
// key_sched_iter
// Iterative AES key schedule: after a start handshake, streams round keys
// one per accepted rk handshake (index 0..10 for AES-128, 0..14 for AES-256).
//
// Configuration macro: KEY_SCHED_AES256_EN
//   defined   - AES-128 and AES-256 supported, 256 bits of key state
//   undefined - AES-128 only, mode and key_in[128:255] ignored, 128-bit state
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start_valid  - request a key expansion
//   start_ready  - high only while idle
//   mode         - 0 AES-128, 1 AES-256 (sampled on start acceptance)
//   key_in       - cipher key, bit 0 is the MSB (sampled on start acceptance)
//   rk_valid     - a round key is presented
//   rk_ready     - consumer accepts the round key
//   rk_data      - current round key, bit 0 is the MSB
//   rk_index     - round number of rk_data
//   rk_last      - qualifies the final round key
// ---------------------------------------------------------------------------
module key_sched_iter #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             mode,
    input  logic [0:KEY_W-1] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:RK_W-1]  rk_data,
    output logic [3:0]       rk_index,
    output logic             rk_last
);

    import aes_pkg::*;

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   idx_nxt;
    logic [127:0] cur_q, cur_d;
    logic [127:0] key_hi;

    logic [127:0] step_base;
    logic [31:0]  step_src;
    logic         step_rot;
    logic [7:0]   step_rcon;
    logic [127:0] step_out;
    logic [3:0]   last_idx;

    logic         accept_start;
    logic         accept_rk;

    assign key_hi  = key_in[0:127];
    assign idx_nxt = idx_q + 4'd1;

`ifdef KEY_SCHED_AES256_EN
    // prev_q holds round key r-2 (or the upper key half before round 1).
    logic [127:0] prev_q, prev_d;
    logic [127:0] key_lo;
    logic         mode_q, mode_d;

    assign key_lo = key_in[128:255];
`else
    logic unused_inputs;

    assign unused_inputs = ^{mode, key_in[128:KEY_W-1]};
`endif

    // Operand selection for the shared step. AES-128 extends the current key
    // with rcon[r]; AES-256 extends key r-2 using the last word of key r-1,
    // rotating and adding rcon[r/2] only on even r (i.e. odd idx_q).
    always_comb begin
        step_base = cur_q;
        step_src  = cur_q[31:0];
        step_rot  = 1'b1;
        step_rcon = rcon_byte(idx_nxt);
        last_idx  = LAST_IDX_128;
`ifdef KEY_SCHED_AES256_EN
        if (mode_q == MODE_AES256) begin
            step_base = prev_q;
            step_rot  = idx_q[0];
            step_rcon = idx_q[0] ? rcon_byte({1'b0, idx_nxt[3:1]}) : 8'h00;
            last_idx  = LAST_IDX_256;
        end
`endif
    end

    key_step u_key_step (
        .base_key (step_base),
        .src_word (step_src),
        .rot_en   (step_rot),
        .rcon_in  (step_rcon),
        .next_key (step_out)
    );

    assign start_ready  = (state_q == IDLE);
    assign rk_valid     = (state_q == GEN);
    assign rk_last      = rk_valid && (idx_q == last_idx);
    assign rk_data      = cur_q;
    assign rk_index     = idx_q;

    assign accept_start = start_valid && start_ready;
    assign accept_rk    = rk_valid && rk_ready;

    // Next-state logic. Key state only moves on a handshake, so a stalled
    // consumer sees stable outputs and idle keeps the last key visible.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
`ifdef KEY_SCHED_AES256_EN
        prev_d  = prev_q;
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_start) begin
                    state_d = GEN;
                    idx_d   = 4'd0;
                    cur_d   = key_hi;
`ifdef KEY_SCHED_AES256_EN
                    prev_d  = key_lo;
                    mode_d  = mode;
`endif
                end
            end
            GEN: begin
                if (accept_rk) begin
                    if (rk_last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_nxt;
                        cur_d = step_out;
`ifdef KEY_SCHED_AES256_EN
                        // Round key 1 of AES-256 is the stashed upper half.
                        if (mode_q == MODE_AES256) begin
                            prev_d = cur_q;
                            if (idx_q == 4'd0) begin
                                cur_d = prev_q;
                            end
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears all key state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cur_q   <= 128'd0;
`ifdef KEY_SCHED_AES256_EN
            prev_q  <= 128'd0;
            mode_q  <= MODE_AES128;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
`ifdef KEY_SCHED_AES256_EN
            prev_q  <= prev_d;
            mode_q  <= mode_d;
`endif
        end
    end

endmodule

// File: doc/key_sched_iter.md
KEY_SCHED_ITER -- requirements
Module: key_sched_iter

Interface
REQ-001 The module SHALL have parameter KEY_W, default 256, meaning the width of key_in; it is fixed at 256 and AES-128 keys occupy key_in[0:127].
REQ-002 The module SHALL have parameter RK_W, default 128, meaning the round-key width.
REQ-003 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  The reset SHALL be asynchronous and active-high.
REQ-005 start_valid  input  1  Asserted to request a key expansion.
REQ-006 start_ready  output  1  High only in state IDLE.
REQ-007 mode  input  1  0 selects AES-128; 1 selects AES-256; sampled only on start acceptance.
REQ-008 key_in  input  [0:KEY_W-1]  Cipher key, bit 0 is the MSB; sampled only on start acceptance.
REQ-009 rk_valid  output  1  A round key is presented.
REQ-010 rk_ready  input  1  The consumer accepts the round key.
REQ-011 rk_data  output  [0:RK_W-1]  Current round key.
REQ-012 rk_index  output  4  Round number of rk_data: 0..10 for AES-128, 0..14 for AES-256.
REQ-013 rk_last  output  1  High together with rk_valid on the final round key.

Function
REQ-014 FSM states SHALL be IDLE and GEN, and the block SHALL move IDLE->GEN on start_valid&&start_ready.
REQ-015 The block SHALL present rk_valid=1 with rk_index=0 in the cycle after start acceptance.
REQ-016 Round key 0 SHALL be key_in[0:127]; for AES-256, round key 1 SHALL be key_in[128:255].
REQ-017 In AES-128, round key r SHALL be computed from round key r-1 as: t = SubWord(RotWord(w3)) ^ {rcon[r],24'h0}; y0 = w0^t; y1 = w1^y0; y2 = w2^y1; y3 = w3^y2.
REQ-018 In AES-256, for r>=2, round key r SHALL be derived from round keys r-2 and r-1; even r SHALL use SubWord(RotWord(last word of r-1))^rcon[r/2], and odd r SHALL use SubWord(last word of r-1) with no rotate and no rcon.
REQ-019 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36, indexed from 1.
REQ-020 Each rk_valid&&rk_ready handshake SHALL advance to the next round key in the following cycle, giving a throughput of one key per cycle under continuous rk_ready.
REQ-021 While rk_valid && !rk_ready, rk_data, rk_index and rk_last SHALL be held stable.
REQ-022 Acceptance of a key with rk_last=1 SHALL return the FSM to IDLE, with start_ready=1 in the next cycle.
REQ-023 start_valid in GEN SHALL be ignored (start_ready=0), and mode and key_in changes in GEN SHALL have no effect.
REQ-024 In IDLE, rk_valid and rk_last SHALL be 0, and rk_data and rk_index SHALL retain their last values.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, start_ready=1, rk_valid=0, rk_last=0, rk_data=0, rk_index=0, and clear the internal key state to 0.
REQ-026 Reset asserted mid-expansion SHALL abandon the expansion, and no further rk_valid SHALL appear until a new start is accepted.

Configuration
REQ-027 With macro KEY_SCHED_AES256_EN defined, both modes SHALL be supported, with 256 bits of key state.
REQ-028 Without KEY_SCHED_AES256_EN, mode SHALL be ignored and treated as 0, key_in[128:255] SHALL be unused, and the key state SHALL be reduced to 128 bits.

Structure
REQ-029 Package aes_pkg SHALL hold the rcon table, the mode encoding constants, and the round-count constants (last index 10 and 14).
REQ-030 The one-word expansion step (RotWord select, four instances of the existing sbox, rcon XOR, XOR chain) SHALL be a combinational sub-module named key_step.
REQ-031 key_sched_iter SHALL instantiate key_step exactly once.

Verification
REQ-032 AES-128 test: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 SHALL produce rk1=a0fafe1788542cb123a339392a6c7605 and rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, and 11 keys in 11 consecutive cycles.
REQ-033 AES-256 test: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 SHALL produce rk2=9ba354118e6925afa51a8b5f2067fcde and rk14=fe4890d1e6188d0b046df344706c631e with rk_last=1.
REQ-034 Backpressure test: rk_ready toggled randomly during an AES-128 expansion SHALL leave outputs stable while stalled and produce the same key sequence as the first test.
REQ-035 Busy-start test: start_valid with a different key at rk_index=3 SHALL be ignored, and the original sequence SHALL complete.
REQ-036 Mid-run reset test: rst at rk_index=5 SHALL give rk_valid=0 and start_ready=1 immediately, and a new start SHALL then restart from rk_index=0.
REQ-037 Macro-off test: without KEY_SCHED_AES256_EN, start with mode=1 and the AES-128 test key SHALL produce the AES-128 sequence ending at rk_index=10.
